// File: rtl/bip_uart_host_pkg.sv
// Shared constants, state encodings and the nibble-to-ASCII helper for the BIP UART host.
package bip_uart_pkg;

  localparam logic [7:0] CMD_RUN = 8'h0D;
  localparam logic [7:0] CMD_ACC = 8'h41;
  localparam logic [7:0] CMD_PC  = 8'h50;
  localparam logic [7:0] CHR_T   = 8'h54;
  localparam logic [7:0] CHR_CR  = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_RESTART,
    ST_RUN,
    ST_LOAD,
    ST_SEND,
    ST_TERM
  } host_st_e;

  // Which value the next report carries; SRC_T is the watchdog marker byte.
  typedef enum logic [1:0] {
    SRC_ACC,
    SRC_PC,
    SRC_T
  } src_e;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_SEND,
    SER_TERM
  } ser_st_e;

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    logic [7:0] n8;
    n8 = {4'h0, n};
    return (n <= 4'd9) ? (8'h30 + n8) : (8'h37 + n8);
  endfunction

endpackage

// File: rtl/bip_uart_host_if.sv
// UART FIFO and BIP core signals seen by the host; master = host controller, slave = FIFOs/core.
interface bip_uart_host_if #(
  parameter int N       = 8,
  parameter int ACC_W   = 16,
  parameter int PC_W    = 11,
  parameter int INSTR_W = 16
);

  logic               empty_uart;
  logic               tx_full;
  logic [N-1:0]       uart_in;
  logic [INSTR_W-1:0] instruction_in;
  logic [PC_W-1:0]    pc_in;
  logic [ACC_W-1:0]   bip_acc_in;
  logic               rd_uart;
  logic               wr_uart;
  logic [N-1:0]       uart_out;
  logic               bip_reset;
  logic               busy;

  modport master (
    input  empty_uart, tx_full, uart_in, instruction_in, pc_in, bip_acc_in,
    output rd_uart, wr_uart, uart_out, bip_reset, busy
  );

  modport slave (
    output empty_uart, tx_full, uart_in, instruction_in, pc_in, bip_acc_in,
    input  rd_uart, wr_uart, uart_out, bip_reset, busy
  );

endinterface

// File: rtl/bip_uart_host_serializer.sv
// Shifts a left-justified value out as uppercase hex ASCII (or the 'T' marker) followed by CR.
// Emits one byte per cycle while tx_full_i=0 and holds otherwise; load_i is only honoured when idle.
module bip_hex_serializer
  import bip_uart_pkg::*;
#(
  parameter int MAX_NIB = 4,
  parameter int CW      = $clog2(MAX_NIB + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 raw_i,
  input  logic [4*MAX_NIB-1:0] value_i,
  input  logic [CW-1:0]        nib_i,
  input  logic                 tx_full_i,
  output logic                 wr_o,
  output logic [7:0]           dat_o,
  output logic                 last_o,
  output logic                 done_o
);

  localparam int VW = 4 * MAX_NIB;

  ser_st_e       st_q, st_d;
  logic [VW-1:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          raw_q, raw_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= SER_IDLE;
      sh_q  <= '0;
      cnt_q <= '0;
      raw_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      raw_q <= raw_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    raw_d  = raw_q;
    wr_o   = 1'b0;
    dat_o  = 8'h00;
    last_o = 1'b0;
    done_o = 1'b0;
    case (st_q)
      SER_IDLE: begin
        if (load_i) begin
          sh_d  = value_i;
          // The marker is a single literal byte, not a hex string.
          cnt_d = raw_i ? CW'(1) : nib_i;
          raw_d = raw_i;
          st_d  = SER_SEND;
        end
      end
      SER_SEND: begin
        if (!tx_full_i) begin
          wr_o  = 1'b1;
          dat_o = raw_q ? CHR_T : nib2ascii(sh_q[VW-1 -: 4]);
          sh_d  = sh_q << 4;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            last_o = 1'b1;
            st_d   = SER_TERM;
          end
        end
      end
      SER_TERM: begin
        if (!tx_full_i) begin
          wr_o   = 1'b1;
          dat_o  = CHR_CR;
          done_o = 1'b1;
          st_d   = SER_IDLE;
        end
      end
      default: st_d = SER_IDLE;
    endcase
  end

endmodule

// File: rtl/bip_uart_host.sv
// Host controller between UART FIFOs and the BIP core: decodes CR/'A'/'P', runs the core, reports ACC/PC.
// Command byte -> rd_uart 1 cycle, rd_uart -> first TX byte 2 cycles; TX stalls on tx_full, RX is not popped while busy.
// Optional watchdog on RUN is enabled by defining BIP_UART_HOST_TIMEOUT_EN.
module bip_uart_host
  import bip_uart_pkg::*;
#(
  parameter int N           = 8,
  parameter int ACC_W       = 16,
  parameter int PC_W        = 11,
  parameter int INSTR_W     = 16,
  parameter int HALT_PC_MIN = 2,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  bip_uart_host_if.master   bus
);

  localparam int ACC_NIB = (ACC_W + 3) / 4;
  localparam int PC_NIB  = (PC_W + 3) / 4;
  localparam int MAX_NIB = (ACC_NIB > PC_NIB) ? ACC_NIB : PC_NIB;
  localparam int VW      = 4 * MAX_NIB;
  localparam int CW      = $clog2(MAX_NIB + 1);

  host_st_e st_q, st_d;
  src_e     src_q, src_d;
  logic     bip_reset_q, bip_reset_d;
  logic     run_arm_q, run_arm_d;
  logic     rd_uart;
  logic     halt;

  logic          ser_load, ser_raw, ser_wr, ser_last, ser_done;
  logic [VW-1:0] ser_val, acc_ext, pc_ext;
  logic [CW-1:0] ser_nib;
  logic [7:0]    ser_dat;

`ifdef BIP_UART_HOST_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] cyc_q, cyc_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= ST_IDLE;
      src_q       <= SRC_ACC;
      bip_reset_q <= 1'b1;
      run_arm_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      src_q       <= src_d;
      bip_reset_q <= bip_reset_d;
      run_arm_q   <= run_arm_d;
    end
  end

`ifdef BIP_UART_HOST_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end
`endif

  // The first RUN cycle is skipped: the core has just left reset and its outputs are stale.
  assign halt = run_arm_q && (bus.instruction_in == '0) &&
                (bus.pc_in >= PC_W'(HALT_PC_MIN));

  always_comb begin
    st_d        = st_q;
    src_d       = src_q;
    bip_reset_d = bip_reset_q;
    run_arm_d   = run_arm_q;
    rd_uart     = 1'b0;
    ser_load    = 1'b0;
`ifdef BIP_UART_HOST_TIMEOUT_EN
    cyc_d       = cyc_q;
`endif
    case (st_q)
      ST_IDLE: begin
        if (!bus.empty_uart) st_d = ST_DECODE;
      end
      ST_DECODE: begin
        rd_uart = 1'b1;
        if (bus.uart_in == N'(CMD_RUN)) begin
          bip_reset_d = 1'b1;
          st_d        = ST_RESTART;
        end else if (bus.uart_in == N'(CMD_ACC)) begin
          src_d = SRC_ACC;
          st_d  = ST_LOAD;
        end else if (bus.uart_in == N'(CMD_PC)) begin
          src_d = SRC_PC;
          st_d  = ST_LOAD;
        end else begin
          st_d = ST_IDLE;
        end
      end
      ST_RESTART: begin
        bip_reset_d = 1'b0;
        run_arm_d   = 1'b0;
`ifdef BIP_UART_HOST_TIMEOUT_EN
        cyc_d       = '0;
`endif
        st_d        = ST_RUN;
      end
      ST_RUN: begin
        run_arm_d = 1'b1;
        if (halt) begin
          src_d = SRC_ACC;
          st_d  = ST_LOAD;
        end
`ifdef BIP_UART_HOST_TIMEOUT_EN
        else if (cyc_q == TO_W'(TIMEOUT_CYC - 1)) begin
          bip_reset_d = 1'b1;
          src_d       = SRC_T;
          st_d        = ST_LOAD;
        end else begin
          cyc_d = cyc_q + TO_W'(1);
        end
`endif
      end
      ST_LOAD: begin
        ser_load = 1'b1;
        st_d     = ST_SEND;
      end
      ST_SEND: begin
        if (ser_last) st_d = ST_TERM;
      end
      ST_TERM: begin
        if (ser_done) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Sources are left-justified so the serializer always starts from its top nibble.
  always_comb begin
    acc_ext              = '0;
    pc_ext               = '0;
    acc_ext[ACC_W-1:0]   = bus.bip_acc_in;
    pc_ext[PC_W-1:0]     = bus.pc_in;
    ser_val              = '0;
    ser_nib              = CW'(ACC_NIB);
    ser_raw              = 1'b0;
    case (src_q)
      SRC_ACC: begin
        ser_val = acc_ext << (4 * (MAX_NIB - ACC_NIB));
        ser_nib = CW'(ACC_NIB);
      end
      SRC_PC: begin
        ser_val = pc_ext << (4 * (MAX_NIB - PC_NIB));
        ser_nib = CW'(PC_NIB);
      end
      SRC_T: begin
        ser_raw = 1'b1;
      end
      default: ser_raw = 1'b0;
    endcase
  end

  bip_hex_serializer #(
    .MAX_NIB (MAX_NIB),
    .CW      (CW)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load_i    (ser_load),
    .raw_i     (ser_raw),
    .value_i   (ser_val),
    .nib_i     (ser_nib),
    .tx_full_i (bus.tx_full),
    .wr_o      (ser_wr),
    .dat_o     (ser_dat),
    .last_o    (ser_last),
    .done_o    (ser_done)
  );

  assign bus.rd_uart   = rd_uart;
  assign bus.wr_uart   = ser_wr;
  assign bus.uart_out  = N'(ser_dat);
  assign bus.bip_reset = bip_reset_q;
  assign bus.busy      = (st_q != ST_IDLE);

endmodule

// File: tb/tb_bip_uart_host.sv
// Directed bench for bip_uart_host: RX FIFO model, expected-byte scoreboard, decoupled TX monitor.
module tb_bip_uart_host;
  import bip_uart_pkg::*;

  logic clk = 1'b0;
  logic reset;

  bip_uart_host_if #(.N(8), .ACC_W(16), .PC_W(11), .INSTR_W(16)) bus ();

  bip_uart_host dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int tx_cnt   = 0;
  int rd_cnt   = 0;
  int rd_cyc   = -1;
  int wr1_cyc  = -1;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic upd_rx();
    bus.empty_uart = (rx_q.size() == 0);
    bus.uart_in    = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_q.push_back(b);
    upd_rx();
  endtask

  task automatic expect_str(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int n);
    if (n > 0) exp_q.push_back(b0);
    if (n > 1) exp_q.push_back(b1);
    if (n > 2) exp_q.push_back(b2);
    if (n > 3) exp_q.push_back(b3);
    exp_q.push_back(8'h0D);
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (n < max && !(bus.busy == 1'b0 && exp_q.size() == 0 && rx_q.size() == 0)) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 32'(n < max), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rd_uart"},   32'(bus.rd_uart),   32'd0);
    chk({tag, "_wr_uart"},   32'(bus.wr_uart),   32'd0);
    chk({tag, "_uart_out"},  32'(bus.uart_out),  32'd0);
    chk({tag, "_bip_reset"}, 32'(bus.bip_reset), 32'd1);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RX FIFO: a pop strobe seen mid-cycle removes the head just after the closing edge.
  initial forever begin
    logic rd_now;
    @(negedge clk);
    rd_now = bus.rd_uart;
    if (rd_now) begin
      rd_cnt++;
      if (rd_cyc < 0) rd_cyc = cyc;
    end
    @(posedge clk); #1;
    if (rd_now && rx_q.size() != 0) void'(rx_q.pop_front());
    upd_rx();
  end

  // TX monitor: every pushed byte is checked against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (bus.wr_uart) begin
      tx_cnt++;
      if (wr1_cyc < 0) wr1_cyc = cyc;
      chk("wr_while_full", 32'(bus.tx_full), 32'd0);
      chk("rd_wr_overlap", 32'(bus.rd_uart), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tx: got byte %0h expected no write", bus.uart_out);
      end else begin
        chk("tx_byte", 32'(bus.uart_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int t0, r0, hi;
    reset              = 1'b1;
    bus.tx_full        = 1'b0;
    bus.instruction_in = 16'hFFFF;
    bus.pc_in          = '0;
    bus.bip_acc_in     = '0;
    upd_rx();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // 'A' report before any run; latency from pop to first write.
    bus.bip_acc_in = 16'h1F3A;
    rd_cyc = -1; wr1_cyc = -1;
    r0 = rd_cnt;
    expect_str(8'h31, 8'h46, 8'h33, 8'h41, 4);
    push_rx(CMD_ACC);
    wait_idle("acc_idle", 60);
    chk("acc_rd_pulses", 32'(rd_cnt - r0), 32'd1);
    chk("acc_latency", 32'(wr1_cyc - rd_cyc), 32'd2);
    chk("acc_bip_reset", 32'(bus.bip_reset), 32'd1);

    // Run: zero instruction at pc=1 must not halt, pc=5 does.
    bus.instruction_in = '0;
    bus.pc_in          = 11'd1;
    bus.bip_acc_in     = 16'h00FF;
    push_rx(CMD_RUN);
    for (int i = 0; i < 20 && bus.bip_reset !== 1'b0; i++) begin
      @(posedge clk); #1;
    end
    chk("run_release", 32'(bus.bip_reset), 32'd0);
    t0 = tx_cnt;
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("no_halt_low_pc", 32'(tx_cnt - t0), 32'd0);
    chk("run_busy", 32'(bus.busy), 32'd1);
    expect_str(8'h30, 8'h30, 8'h46, 8'h46, 4);
    bus.pc_in = 11'd5;
    wait_idle("halt_idle", 60);
    chk("halt_bip_reset", 32'(bus.bip_reset), 32'd0);

    // PC report: 11 bits -> 3 hex characters.
    bus.pc_in = 11'h7A2;
    expect_str(8'h37, 8'h41, 8'h32, 8'h00, 3);
    push_rx(CMD_PC);
    wait_idle("pc_idle", 60);
    chk("pc_bip_reset", 32'(bus.bip_reset), 32'd0);

    // Second run from a released core: bip_reset pulses high for one cycle.
    bus.pc_in      = 11'd5;
    bus.bip_acc_in = 16'hABCD;
    expect_str(8'h41, 8'h42, 8'h43, 8'h44, 4);
    push_rx(CMD_RUN);
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.bip_reset) hi++;
    end
    chk("restart_pulse", 32'(hi), 32'd1);
    wait_idle("rerun_idle", 60);

    // TX backpressure mid-report.
    bus.bip_acc_in = 16'hBEEF;
    expect_str(8'h42, 8'h45, 8'h45, 8'h46, 4);
    t0 = tx_cnt;
    push_rx(CMD_ACC);
    for (int i = 0; i < 40 && (tx_cnt - t0) < 2; i++) begin
      @(posedge clk); #1;
    end
    bus.tx_full = 1'b1;
    t0 = tx_cnt;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("stall_no_write", 32'(tx_cnt - t0), 32'd0);
    chk("stall_busy", 32'(bus.busy), 32'd1);
    bus.tx_full = 1'b0;
    wait_idle("stall_idle", 60);

    // Unknown byte is discarded silently, next command still answered.
    bus.bip_acc_in = 16'h0009;
    expect_str(8'h30, 8'h30, 8'h30, 8'h39, 4);
    r0 = rd_cnt;
    t0 = tx_cnt;
    push_rx(8'h78);
    push_rx(CMD_ACC);
    wait_idle("junk_idle", 80);
    chk("junk_rd_pulses", 32'(rd_cnt - r0), 32'd2);
    chk("junk_tx_count", 32'(tx_cnt - t0), 32'd5);

    // Reset in the middle of SEND abandons the string.
    bus.bip_acc_in = 16'hC0DE;
    exp_q.push_back(8'h43);
    t0 = tx_cnt;
    push_rx(CMD_ACC);
    for (int i = 0; i < 40 && tx_cnt == t0; i++) begin
      @(posedge clk); #1;
    end
    chk("midsend_first", 32'(tx_cnt - t0), 32'd1);
    bus.tx_full = 1'b1;
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_reset_vals("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    bus.tx_full = 1'b0;
    t0 = tx_cnt;
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("post_reset_quiet", 32'(tx_cnt - t0), 32'd0);
    chk("post_reset_busy", 32'(bus.busy), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
